// File: rtl/divn_pkg.sv
// Shared constants for the divn pulse divider.
package divn_pkg;

  localparam int unsigned DIVN_WIDTH = 32;

  localparam logic EDGE_RISE   = 1'b0;
  localparam logic EDGE_FALL   = 1'b1;

  localparam logic MODE_FOLLOW = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/divn_edge_det.sv
// Optional input synchroniser plus counted-edge and active-level detection.
module divn_edge_det #(
  parameter bit SYNC_INP = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inp_i,
  input  logic enable_i,
  input  logic edge_sel_i,
  output logic edge_o,
  output logic act_o,
  output logic en_o
);

  logic lvl;
  logic prev_q;

  if (SYNC_INP) begin : g_sync
    logic [1:0] inp_q;
    logic [1:0] en_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        inp_q <= '0;
        en_q  <= '0;
      end else begin
        inp_q <= {inp_q[0], inp_i};
        en_q  <= {en_q[0], enable_i};
      end
    end
    assign lvl  = inp_q[1];
    assign en_o = en_q[1];
  end else begin : g_nosync
    assign lvl  = inp_i;
    assign en_o = enable_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) prev_q <= 1'b0;
    else         prev_q <= lvl;
  end

  // An edge counts only on a real transition into the selected level.
  assign act_o  = lvl ^ edge_sel_i;
  assign edge_o = act_o & (lvl ^ prev_q);

endmodule

// File: rtl/divn.sv
// Programmable pulse divider routing every D-th counted pulse to outd_o.
// Pulse output mode is compiled in with DIVN_PULSE_MODE_EN.
module divn
  import divn_pkg::*;
#(
  parameter int unsigned WIDTH    = DIVN_WIDTH,
  parameter bit          SYNC_INP = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inp_i,
  input  logic             enable_i,
  output logic             outd_o,
  output logic             outn_o,
  input  logic [WIDTH-1:0] DIVISOR,
  input  logic             DIVISOR_WSTB,
  input  logic             FIRST_PULSE,
  input  logic             FIRST_PULSE_WSTB,
  input  logic             EDGE,
  input  logic             OUT_MODE,
  output logic [WIDTH-1:0] COUNT
);

  logic             edge_s;
  logic             act_s;
  logic             en_s;
  logic             pulse_sel;
  logic             wstb;
  logic             cont;
  logic [WIDTH-1:0] dm1;
  logic [WIDTH-1:0] preset;

  logic [WIDTH-1:0] div_q, div_d;
  logic             fp_q, fp_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             outd_q, outd_d;
  logic             outn_q, outn_d;
  logic             pol_q, pol_d;
  logic             pulse_q, pulse_d;

  divn_edge_det #(
    .SYNC_INP (SYNC_INP)
  ) u_edge (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inp_i      (inp_i),
    .enable_i   (enable_i),
    .edge_sel_i (EDGE),
    .edge_o     (edge_s),
    .act_o      (act_s),
    .en_o       (en_s)
  );

`ifdef DIVN_PULSE_MODE_EN
  assign pulse_sel = (OUT_MODE == MODE_PULSE);
`else
  logic unused_out_mode;
  assign unused_out_mode = OUT_MODE;
  assign pulse_sel       = 1'b0;
`endif

  assign wstb = DIVISOR_WSTB | FIRST_PULSE_WSTB;
  // Follow output tracks the level that started it, even if EDGE changed.
  assign cont = act_s ^ (EDGE ^ pol_q);

  always_comb begin
    div_d   = DIVISOR_WSTB ? DIVISOR : div_q;
    fp_d    = FIRST_PULSE_WSTB ? FIRST_PULSE : fp_q;
    dm1     = (div_d == '0) ? '0 : div_d - 1'b1;
    preset  = fp_d ? dm1 : '0;
    cnt_d   = cnt_q;
    outd_d  = 1'b0;
    outn_d  = 1'b0;
    pol_d   = pol_q;
    pulse_d = pulse_q;
    unique case (1'b1)
      (!en_s || wstb): begin
        cnt_d = preset;
      end
      (en_s && !wstb && edge_s): begin
        pol_d   = EDGE;
        pulse_d = pulse_sel;
        if (cnt_q >= dm1) begin
          outd_d = 1'b1;
          cnt_d  = '0;
        end else begin
          outn_d = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      (en_s && !wstb && !edge_s): begin
        if (!pulse_q) begin
          outd_d = outd_q & cont;
          outn_d = outn_q & cont;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_q   <= '0;
      fp_q    <= 1'b0;
      cnt_q   <= '0;
      outd_q  <= 1'b0;
      outn_q  <= 1'b0;
      pol_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      fp_q    <= fp_d;
      cnt_q   <= cnt_d;
      outd_q  <= outd_d;
      outn_q  <= outn_d;
      pol_q   <= pol_d;
      pulse_q <= pulse_d;
    end
  end

  assign outd_o = outd_q;
  assign outn_o = outn_q;
  assign COUNT  = cnt_q;

endmodule

// File: tb/tb_divn.sv
// Directed self-checking bench for divn (default WIDTH, SYNC_INP=0).
module tb_divn;

  logic        clk;
  logic        reset;
  logic        inp;
  logic        en;
  logic        outd;
  logic        outn;
  logic [31:0] div;
  logic        div_wstb;
  logic        fp;
  logic        fp_wstb;
  logic        edge_sel;
  logic        mode;
  logic [31:0] count;

  int n_chk;
  int n_fail;

  divn dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .inp_i            (inp),
    .enable_i         (en),
    .outd_o           (outd),
    .outn_o           (outn),
    .DIVISOR          (div),
    .DIVISOR_WSTB     (div_wstb),
    .FIRST_PULSE      (fp),
    .FIRST_PULSE_WSTB (fp_wstb),
    .EDGE             (edge_sel),
    .OUT_MODE         (mode),
    .COUNT            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_div(input logic [31:0] v);
    div      = v;
    div_wstb = 1'b1;
    tick();
    div_wstb = 1'b0;
  endtask

  task automatic wr_fp(input logic v);
    fp      = v;
    fp_wstb = 1'b1;
    tick();
    fp_wstb = 1'b0;
  endtask

  // Rising pulse, two cycles high then low, in follow mode.
  task automatic pulse(input string tag, input logic ed, input logic en_n,
                       input logic [31:0] c);
    inp = 1'b1;
    tick();
    check({tag, " outd"}, {31'd0, outd}, {31'd0, ed});
    check({tag, " outn"}, {31'd0, outn}, {31'd0, en_n});
    check({tag, " count"}, count, c);
    tick();
    check({tag, " hold"}, {30'd0, outd, outn}, {30'd0, ed, en_n});
    inp = 1'b0;
    tick();
    check({tag, " fall"}, {30'd0, outd, outn}, 32'd0);
  endtask

  always @(negedge clk)
    if (!reset) check("excl", {31'd0, outd & outn}, 32'd0);

  initial begin
    logic pm;
`ifdef DIVN_PULSE_MODE_EN
    pm = 1'b1;
`else
    pm = 1'b0;
`endif
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    inp      = 1'b0;
    en       = 1'b0;
    div      = '0;
    div_wstb = 1'b0;
    fp       = 1'b0;
    fp_wstb  = 1'b0;
    edge_sel = 1'b0;
    mode     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst outd", {31'd0, outd}, 32'd0);
    check("rst outn", {31'd0, outn}, 32'd0);
    check("rst count", count, 32'd0);
    reset = 1'b0;
    tick();

    // Divide by 3, first pulse to outn
    wr_div(32'd3);
    wr_fp(1'b0);
    check("d3 preset", count, 32'd0);
    en = 1'b1;
    tick();
    pulse("d3 p1", 1'b0, 1'b1, 32'd1);
    pulse("d3 p2", 1'b0, 1'b1, 32'd2);
    pulse("d3 p3", 1'b1, 1'b0, 32'd0);
    pulse("d3 p4", 1'b0, 1'b1, 32'd1);
    pulse("d3 p5", 1'b0, 1'b1, 32'd2);
    pulse("d3 p6", 1'b1, 1'b0, 32'd0);

    // First pulse to outd
    en = 1'b0;
    tick();
    wr_fp(1'b1);
    check("fp1 preset", count, 32'd2);
    inp = 1'b1;
    tick();
    check("dis outs", {30'd0, outd, outn}, 32'd0);
    inp = 1'b0;
    tick();
    en = 1'b1;
    tick();
    pulse("fp1 p1", 1'b1, 1'b0, 32'd0);
    pulse("fp1 p2", 1'b0, 1'b1, 32'd1);
    pulse("fp1 p3", 1'b0, 1'b1, 32'd2);
    pulse("fp1 p4", 1'b1, 1'b0, 32'd0);

    // Divisor 0 and 1 both divide by one
    en = 1'b0;
    wr_div(32'd0);
    check("d0 preset", count, 32'd0);
    en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) pulse("d0", 1'b1, 1'b0, 32'd0);
    en = 1'b0;
    wr_div(32'd1);
    en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) pulse("d1", 1'b1, 1'b0, 32'd0);

    // Falling edges, divide by 2, OUT_MODE=1
    en = 1'b0;
    wr_fp(1'b0);
    wr_div(32'd2);
    edge_sel = 1'b1;
    mode     = 1'b1;
    inp      = 1'b1;
    tick();
    tick();
    en = 1'b1;
    tick();
    check("fall idle", {30'd0, outd, outn}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      inp = 1'b0;
      tick();
      check("fall first", {30'd0, outd, outn},
            (k % 2 == 0) ? 32'd1 : 32'd2);
      check("fall count", count, (k % 2 == 0) ? 32'd1 : 32'd0);
      for (int j = 0; j < 4; j++) begin
        tick();
        check("fall later", {30'd0, outd, outn},
              pm ? 32'd0 : ((k % 2 == 0) ? 32'd1 : 32'd2));
      end
      inp = 1'b1;
      tick();
      check("fall end", {30'd0, outd, outn}, 32'd0);
      tick();
    end

    // Write strobe coincident with a counted edge
    en       = 1'b0;
    edge_sel = 1'b0;
    mode     = 1'b0;
    inp      = 1'b0;
    tick();
    wr_div(32'd3);
    en = 1'b1;
    tick();
    pulse("ws pre", 1'b0, 1'b1, 32'd1);
    inp      = 1'b1;
    div      = 32'd4;
    div_wstb = 1'b1;
    tick();
    div_wstb = 1'b0;
    check("ws outs", {30'd0, outd, outn}, 32'd0);
    check("ws count", count, 32'd0);
    tick();
    check("ws held", {30'd0, outd, outn}, 32'd0);
    inp = 1'b0;
    tick();
    pulse("d4 p1", 1'b0, 1'b1, 32'd1);
    pulse("d4 p2", 1'b0, 1'b1, 32'd2);
    pulse("d4 p3", 1'b0, 1'b1, 32'd3);
    pulse("d4 p4", 1'b1, 1'b0, 32'd0);

    // Level already active at enable does not count
    en  = 1'b0;
    inp = 1'b1;
    tick();
    tick();
    en = 1'b1;
    tick();
    check("en lvl", {30'd0, outd, outn}, 32'd0);
    tick();
    check("en lvl2", {30'd0, outd, outn}, 32'd0);
    inp = 1'b0;
    tick();
    pulse("en p1", 1'b0, 1'b1, 32'd1);

    // Async reset mid outd pulse, then enable drop mid pulse
    en = 1'b0;
    wr_div(32'd1);
    en = 1'b1;
    tick();
    inp = 1'b1;
    tick();
    check("ar pre", {31'd0, outd}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar outd", {31'd0, outd}, 32'd0);
    check("ar count", count, 32'd0);
    inp = 1'b0;
    #1 reset = 1'b0;
    tick();
    check("ar after", {30'd0, outd, outn}, 32'd0);
    inp = 1'b1;
    tick();
    check("en drop pre", {31'd0, outd}, 32'd1);
    en = 1'b0;
    tick();
    check("en drop", {30'd0, outd, outn}, 32'd0);
    check("en drop cnt", count, 32'd0);
    inp = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
